cpu_0_jtag_debug_module_host: RTL



---
 rtl/cpu_0_jtag_debug_module_host_pkg.sv | 10 +
 rtl/cpu_0_jtag_debug_module_host_tckgen.sv | 31 +++
 rtl/cpu_0_jtag_debug_module_host.sv | 99 +++++++++
 3 files changed

// File: rtl/cpu_0_jtag_debug_module_host_pkg.sv
// cpu_0_jtag_debug_module_host_pkg: shared FSM states, default widths and virtual IR encodings
package cpu_0_jtag_debug_module_host_pkg;
  localparam int SR_WIDTH_DEF = 38;
  localparam int IR_WIDTH_DEF = 2;
  localparam logic [1:0] IR_OCIMEM    = 2'd0;
  localparam logic [1:0] IR_TRACEMEM  = 2'd1;
  localparam logic [1:0] IR_BREAK     = 2'd2;
  localparam logic [1:0] IR_TRACECTRL = 2'd3;
  typedef enum logic [2:0] {ST_IDLE, ST_UIR, ST_CDR, ST_SDR, ST_UDR, ST_RTI, ST_DONE} state_e;
endpackage

// File: rtl/cpu_0_jtag_debug_module_host_tckgen.sv
// cpu_0_jtag_debug_module_host_tckgen: vji_tck divider with one-clk strobes marking the edge where tck rises/falls
module cpu_0_jtag_debug_module_host_tckgen #(
  parameter int TCK_HALF = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  output logic tck_o,
  output logic rise_o,
  output logic fall_o
);
  logic [7:0] cnt_q;
  logic tck_q, arm_q, run, hit;
  // one armed cycle after enable aligns the first period so DONE lands on the spec latency
  assign run = en_i && arm_q;
  assign hit = run && cnt_q == 8'(TCK_HALF - 1);
  assign rise_o = hit && !tck_q;
  assign fall_o = hit && tck_q;
  assign tck_o = tck_q;
  always_ff @(posedge clk) begin
    if (reset || !en_i) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
      arm_q <= 1'b0;
    end else begin
      arm_q <= 1'b1;
      cnt_q <= !run ? cnt_q : hit ? '0 : cnt_q + 8'd1;
      tck_q <= tck_q ^ hit;
    end
  end
endmodule

// File: rtl/cpu_0_jtag_debug_module_host.sv
// cpu_0_jtag_debug_module_host: virtual JTAG scan host (UIR/CDR/SDR/UDR/RTI per request).
// Define CPU_0_JTAG_HOST_IR_CACHE_EN to skip UIR when the requested IR is already loaded.
module cpu_0_jtag_debug_module_host
  import cpu_0_jtag_debug_module_host_pkg::*;
#(
  parameter int TCK_HALF = 2,
  parameter int SR_WIDTH = SR_WIDTH_DEF,
  parameter int IR_WIDTH = IR_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [SR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  output logic [SR_WIDTH-1:0] rsp_data,
  output logic                vji_tck,
  output logic                vji_tdi,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti,
  input  logic                vji_tdo,
  input  logic [IR_WIDTH-1:0] vji_ir_out
);
  localparam int BW = $clog2(SR_WIDTH + 1);
  state_e state_q, state_d;
  logic [SR_WIDTH-1:0] shreg_q, rsp_data_q;
  logic [BW-1:0] bit_q;
  logic [IR_WIDTH-1:0] ir_in_q, ir_out_unused_q;
  logic [4:0] flags_q;
  logic tck, rise, fall, tdi_q, ready_q, rsp_valid_q, skip_uir, accept, last_bit;
  assign accept = state_q == ST_IDLE && cmd_valid;
  assign last_bit = bit_q == BW'(SR_WIDTH - 1);
`ifdef CPU_0_JTAG_HOST_IR_CACHE_EN
  logic ir_loaded_q;
  always_ff @(posedge clk) ir_loaded_q <= reset ? 1'b0 : ir_loaded_q | accept;
  assign skip_uir = ir_loaded_q && cmd_ir == ir_in_q;
`else
  assign skip_uir = 1'b0;
`endif
  cpu_0_jtag_debug_module_host_tckgen #(.TCK_HALF(TCK_HALF)) u_tckgen (
    .clk    (clk),
    .reset  (reset),
    .en_i   (state_q != ST_IDLE && state_q != ST_DONE),
    .tck_o  (tck),
    .rise_o (rise),
    .fall_o (fall)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = accept ? (skip_uir ? ST_CDR : ST_UIR) : ST_IDLE;
      ST_UIR:  state_d = fall ? ST_CDR : ST_UIR;
      ST_CDR:  state_d = fall ? ST_SDR : ST_CDR;
      ST_SDR:  state_d = fall && last_bit ? ST_UDR : ST_SDR;
      ST_UDR:  state_d = fall ? ST_RTI : ST_UDR;
      ST_RTI:  state_d = fall ? ST_DONE : ST_RTI;
      default: state_d = ST_IDLE;
    endcase
  end
  // tdi only follows shreg[0] on edges that leave tck low, so it is stable across every high phase
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      ready_q         <= 1'b1;
      rsp_valid_q     <= 1'b0;
      rsp_data_q      <= '0;
      shreg_q         <= '0;
      bit_q           <= '0;
      tdi_q           <= 1'b0;
      ir_in_q         <= '0;
      ir_out_unused_q <= '0;
      flags_q         <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= state_d == ST_IDLE;
      rsp_valid_q <= state_d == ST_DONE;
      flags_q     <= {state_d == ST_UIR, state_d == ST_CDR, state_d == ST_SDR, state_d == ST_UDR, state_d == ST_RTI};
      bit_q       <= state_q == ST_SDR ? bit_q + BW'(fall) : '0;
      tdi_q       <= state_d != ST_SDR ? 1'b0 : (tck ^ rise ^ fall) ? tdi_q : shreg_q[0];
      if (accept) shreg_q <= cmd_data;
      else if (state_q == ST_SDR && rise) shreg_q <= {vji_tdo, shreg_q[SR_WIDTH-1:1]};
      if (accept && !skip_uir) ir_in_q <= cmd_ir;
      if (state_q == ST_UIR) ir_out_unused_q <= vji_ir_out;
      if (state_d == ST_DONE) rsp_data_q <= shreg_q;
    end
  end
  assign cmd_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign vji_tck   = tck;
  assign vji_tdi   = tdi_q;
  assign vji_ir_in = ir_in_q;
  assign {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti} = flags_q;
endmodule
